// File: rtl/uart_pkg.sv
// Shared UART definitions for the Rx and Tx paths: FSM states, parity encodings, frame sizes.
// The Rx parity check is enabled by defining UART_RX_PARITY_CHECK_EN.
package uart_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int FRAME_BITS = 11;
    localparam int CNT_W      = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_e;

    // 2'b11 is a second encoding of "no parity" on the ParityType pins
    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_ODD      = 2'b01,
        PAR_EVEN     = 2'b10,
        PAR_NONE_ALT = 2'b11
    } par_type_e;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity block shared by Rx (error check) and Tx (bit generation).
// Generates the parity bit for data_i and flags a mismatch against parity_bit_i.
module uart_parity_calc
    import uart_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  parity_bit_i,
    input  par_type_e             parity_type_i,
    output logic                  parity_bit_o,
    output logic                  parity_error_o
);

    logic data_xor;

    assign data_xor = ^data_i;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        parity_bit_o   = 1'b0;
        parity_error_o = 1'b0;
        case (parity_type_i)
            PAR_ODD: begin
                parity_bit_o   = ~data_xor;
                parity_error_o = ~(data_xor ^ parity_bit_i);
            end
            PAR_EVEN: begin
                parity_bit_o   = data_xor;
                parity_error_o = data_xor ^ parity_bit_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/uart_rx_frame_deserializer.sv
// UART receive deserializer: samples DataTx on every BaudOut edge and delivers bytes through a
// one-deep valid/ready buffer. Define UART_RX_PARITY_CHECK_EN to enable the parity check.
module uart_rx_frame_deserializer
    import uart_pkg::*;
(
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  BaudOut,
    input  logic                  DataTx,
    input  logic [1:0]            ParityType,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  RxValid,
    input  logic                  RxReady,
    output logic                  ParityError,
    output logic                  StopError,
    output logic                  Overrun,
    output logic                  Busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic                  baud_q;
    logic                  tick;
    rx_state_e             state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      count_q;
    logic                  pbit_q;
    logic [1:0]            ptype_q;
    logic                  busy_q;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  ovr_q, ovr_d;

    logic                  frame_done;
    logic                  load;
    logic                  accept;
    logic                  parity_err;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            baud_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples
            // pre-edge values, independent of statement order.
            baud_q <= BaudOut;
        end
    end

    // Either BaudOut edge is a bit centre; the tick is high for the cycle after the edge
    assign tick = BaudOut ^ baud_q;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            count_q <= '0;
            pbit_q  <= 1'b0;
            ptype_q <= 2'b00;
            busy_q  <= 1'b0;
        end else if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!DataTx) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (!DataTx) begin
                        state_q <= S_DATA;
                        count_q <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_DATA: begin
                    shift_q <= {DataTx, shift_q[DATA_WIDTH-1:1]};
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_BIT) begin
                        state_q <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    pbit_q  <= DataTx;
                    ptype_q <= ParityType;
                    state_q <= S_STOP;
                end
                S_STOP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_CHECK_EN
    logic unused_gen_bit;

    uart_parity_calc u_parity (
        .data_i         (shift_q),
        .parity_bit_i   (pbit_q),
        .parity_type_i  (par_type_e'(ptype_q)),
        .parity_bit_o   (unused_gen_bit),
        .parity_error_o (parity_err)
    );
`else
    // The parity slot is still clocked through to keep alignment, then discarded
    logic unused_parity;

    assign unused_parity = ^{ptype_q, pbit_q};
    assign parity_err    = 1'b0;
`endif

    assign frame_done = tick && (state_q == S_STOP);
    assign accept     = valid_q && RxReady;
    assign load       = frame_done && (!valid_q || RxReady);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        perr_d  = perr_q;
        serr_d  = serr_q;
        ovr_d   = ovr_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = parity_err;
            serr_d  = ~DataTx;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            ovr_d = 1'b0;
        end
        // A completed frame that cannot be loaded is dropped and remembered
        if (frame_done && !load) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            // NOTE: the byte buffer is reset too: it is a handful of flops, and the flags must
            // read 0 out of reset.
            valid_q <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign RxData      = data_q;
    assign RxValid     = valid_q;
    assign ParityError = perr_q;
    assign StopError   = serr_q;
    assign Overrun     = ovr_q;
    assign Busy        = busy_q;

endmodule
